// File: rtl/neg_serial_arbiter.sv
// rtl/neg_serial_arbiter.sv - round-robin arbiter feeding a single bit-serial two's-complement negation slice
module neg_serial_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [IDW-1:0]         rsp_id,
  output logic                   rsp_ovf,
  output logic                   busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nx;
  logic [IDW-1:0]   ptr, id_q, gnt_idx;
  logic [N_REQ-1:0] gnt_oh;
  logic             gnt_found;
  logic [WIDTH-1:0] gnt_data;
  logic [WIDTH-1:0] op, result, result_nx;
  logic [CW-1:0]    count;
  logic             carry, ovf, last_bit, b;
  logic [WIDTH-1:0] rsp_data_q;
  logic [IDW-1:0]   rsp_id_q;
  logic             rsp_ovf_q;

  // Two passes give the wrap-around search: first above ptr, then from 0 up to ptr.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_oh    = '0;
    gnt_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_found && req_valid[i] && (IDW'(i) > ptr)) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(i);
        gnt_oh[i] = 1'b1;
        gnt_data  = req_data[i*WIDTH +: WIDTH];
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_found && req_valid[i] && (IDW'(i) <= ptr)) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(i);
        gnt_oh[i] = 1'b1;
        gnt_data  = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign last_bit = (count == CW'(WIDTH-1));
  assign b        = ~op[count];

  always_comb begin
    result_nx        = result;
    result_nx[count] = b ^ carry;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (gnt_found) state_nx = SHIFT;
      SHIFT:   if (last_bit)  state_nx = DONE;
      DONE:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= IDW'(N_REQ-1);
      id_q       <= '0;
      op         <= '0;
      result     <= '0;
      carry      <= 1'b0;
      count      <= '0;
      ovf        <= 1'b0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      rsp_ovf_q  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (gnt_found) begin
            op    <= gnt_data;
            ptr   <= gnt_idx;
            id_q  <= gnt_idx;
            carry <= 1'b1;
            count <= '0;
            ovf   <= (gnt_data == MOST_NEG);
          end
        end
        SHIFT: begin
          result <= result_nx;
          carry  <= b & carry;
          count  <= count + 1'b1;
          // Response registers load only here so they stay frozen between operations.
          if (last_bit) begin
            rsp_data_q <= result_nx;
            rsp_id_q   <= id_q;
            rsp_ovf_q  <= ovf;
          end
        end
        default: ;
      endcase
    end
  end

  // Gating with rst_n keeps req_ready low while reset is held.
  assign req_ready = (state == IDLE && rst_n) ? gnt_oh : '0;
  assign rsp_valid = (state == DONE);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_neg_serial_arbiter.sv
// tb/tb_neg_serial_arbiter.sv - randomized self-checking bench for neg_serial_arbiter
module tb_neg_serial_arbiter;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_data;
  logic [IDW-1:0] rsp_id;
  logic           rsp_ovf;
  logic           busy;

  neg_serial_arbiter #(.N_REQ(N), .WIDTH(W), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_ovf(rsp_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int mptr;
  int ops [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input int mask);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (mptr + k) % N;
      if (((mask >> idx) & 1) != 0) return idx;
    end
    return -1;
  endfunction

  task automatic set_req(input int mask);
    req_valid = N'(mask);
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(ops[i]);
  endtask

  // Called at a negedge with the arbiter idle and requests already driven.
  task automatic do_op(input int bp, output int g, output int acc);
    int exp_data, exp_ovf, op;
    #1;
    g = pick(int'(req_valid));
    check("req_ready_idle", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    acc = cyc;
    if (g < 0) begin
      @(negedge clk);
      return;
    end
    op       = ops[g];
    mptr     = g;
    exp_data = ((1 << W) - op) % (1 << W);
    exp_ovf  = (op == (1 << (W-1))) ? 1 : 0;
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      check("shift_valid", 32'(rsp_valid), 32'd0);
      check("shift_busy", 32'(busy), 32'd1);
      check("shift_ready", 32'(req_ready), 32'd0);
      rsp_ready = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    check("done_valid", 32'(rsp_valid), 32'd1);
    check("done_data", 32'(rsp_data), 32'(exp_data));
    check("done_id", 32'(rsp_id), 32'(g));
    check("done_ovf", 32'(rsp_ovf), 32'(exp_ovf));
    check("done_ready", 32'(req_ready), 32'd0);
    for (int k = 0; k < bp; k++) begin
      rsp_ready = 1'b0;
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data", 32'(rsp_data), 32'(exp_data));
      check("bp_id", 32'(rsp_id), 32'(g));
      check("bp_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("post_valid", 32'(rsp_valid), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("post_data_hold", 32'(rsp_data), 32'(exp_data));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    check({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    check({tag, "_rsp_ovf"}, 32'(rsp_ovf), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    mptr = N - 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, acc, prev_acc;
    int bnd [4];
    int fair_order [5];
    bnd = '{8'h00, 8'h80, 8'h7F, 8'hFF};
    fair_order = '{0, 1, 2, 3, 0};

    rst_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    rsp_ready = 1'b0;
    mptr = N - 1;
    for (int i = 0; i < N; i++) ops[i] = 0;

    @(negedge clk);
    req_valid = '1;
    #1;
    check_zero_outputs("reset");
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    ops[0] = 8'h05;
    set_req(4'b0001);
    do_op(0, g, acc);
    check("single_gnt", 32'(g), 32'd0);

    for (int i = 0; i < 4; i++) begin
      ops[2] = bnd[i];
      set_req(4'b0100);
      do_op(int'($urandom_range(0, 2)), g, acc);
      check("bnd_gnt", 32'(g), 32'd2);
    end

    pulse_reset();
    for (int i = 0; i < N; i++) ops[i] = i + 1;
    set_req(4'b1111);
    prev_acc = -1;
    for (int i = 0; i < 5; i++) begin
      do_op(0, g, acc);
      check("fair_order", 32'(g), 32'(fair_order[i]));
      if (prev_acc >= 0) check("fair_interval", 32'(acc - prev_acc), 32'(W + 2));
      prev_acc = acc;
    end

    ops[0] = 8'h33;
    ops[1] = 8'h44;
    set_req(4'b0011);
    do_op(5, g, acc);
    prev_acc = acc;
    do_op(0, g, acc);
    check("bp_pending_interval", 32'(acc - prev_acc), 32'(W + 2 + 5));

    ops[0] = 8'h5A;
    set_req(4'b0001);
    pulse_reset();
    set_req(4'b0001);
    @(posedge clk);
    for (int k = 0; k < 4; k++) @(negedge clk);
    check("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    ops[0] = 0;
    set_req(4'b1010);
    @(negedge clk);
    rst_n = 1'b1;
    mptr = N - 1;
    do_op(0, g, acc);
    check("post_rst_gnt", 32'(g), 32'd1);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) ops[i] = int'($urandom_range(0, 255));
      if (t % 7 == 3) ops[$urandom_range(0, N-1)] = 8'h80;
      set_req(($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 15)));
      do_op(int'($urandom_range(0, 3)), g, acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/neg_serial_arbiter.md
Name: neg_serial_arbiter

Overview:
- Round-robin arbiter and bit-serial sequencer that shares one full-adder bit slice among N_REQ requesters.
- Each accepted operand is two's-complement negated (result = ~A + 1) one bit per clock, LSB first, with a single carry flop.
- Sits between operand producers and the negation consumer.
- Trades the 8-slice ripple datapath for one slice plus control.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/result width in bits.
- IDW, 2, width of rsp_id; must be >= clog2(N_REQ).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  N_REQ  per-requester operand valid.
- req_data  input  N_REQ*WIDTH  operands; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  output  N_REQ  one-hot grant/accept strobe.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  WIDTH  negated operand.
- rsp_id  output  IDW  index of the requester that owns rsp_data.
- rsp_ovf  output  1  operand was the most negative value (1 followed by WIDTH-1 zeros); result equals operand.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, shift/result regs=0, carry=0, bit counter=0.
  - Outputs: req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_ovf=0, busy=0.
  - Round-robin pointer = N_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - Grant goes to the first requester with req_valid=1, searching from ptr+1 upward with wrap.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - Acceptance = req_valid[g] & req_ready[g] at a rising edge.
  - On acceptance: capture req_data[g] into the operand register, ptr<=g, id<=g, carry<=1, count<=0.
  - On acceptance: ovf flag <= (operand == {1'b1,{WIDTH-1{1'b0}}}); next state SHIFT.
  - No valid requests: stay in IDLE, req_ready=0.
- SHIFT, one bit per cycle:
  - b = ~op[count]
  - result[count] <= b ^ carry
  - carry <= b & carry
  - count <= count+1
  - At count==WIDTH-1: final carry is discarded; next state DONE.
  - req_ready=0 throughout.
- DONE:
  - rsp_valid=1; rsp_data, rsp_id and rsp_ovf are held stable until rsp_ready=1 at a rising edge.
  - After that handshake, next state is IDLE.
  - No new acceptance in the handshake cycle; req_ready=0 in DONE.
- Latency: rsp_valid rises exactly WIDTH clock edges after the acceptance edge. Minimum issue interval is WIDTH+2 cycles.
- Arithmetic:
  - Modulo 2^WIDTH.
  - Input 0 yields 0 with ovf=0.
  - Most-negative input yields itself with ovf=1.
- req_data only needs to be stable in the acceptance cycle. A requester may drop req_valid without being granted; no grant is made to a requester whose valid is low.
- rsp_ready while rsp_valid=0 is ignored.
- rsp_data/rsp_id/rsp_ovf keep their last values after the handshake until the next DONE. The check is made only when rsp_valid=1.
- Reset mid-SHIFT or mid-DONE: the operation is aborted with no response, all state returns to reset values, and the next grant starts at requester 0.

Test Plan:
- Single op: req_valid[0]=1, req_data[0]=0x05.
  - Expect req_ready[0] pulse; 8 edges later rsp_valid=1, rsp_data=0xFB, rsp_id=0, rsp_ovf=0, busy=1 during op.
- Boundary operands, sequential on requester 2:
  - 0x00 -> 0x00, ovf=0.
  - 0x80 -> 0x80, ovf=1.
  - 0x7F -> 0x81, ovf=0.
  - 0xFF -> 0x01, ovf=0.
  - rsp_id=2 for all four.
- Fairness: all four req_valid held high with distinct operands 0x01..0x04 and rsp_ready=1.
  - Expect grant order 0,1,2,3,0.
  - rsp_data 0xFF, 0xFE, 0xFD, 0xFC.
  - Issue interval 10 cycles.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid.
  - Expect rsp_data/rsp_id stable, rsp_valid held, req_ready=0 while another request is pending.
  - Pending request is granted the cycle after the handshake.
- Reset mid-op: assert rst_n=0 at the 4th SHIFT cycle.
  - Expect all outputs 0 immediately (asynchronous).
  - After release with req_valid=4'b1010, first grant goes to requester 1.
